// File: rtl/seq_detect_n_if.sv
// Serial-stream side of seq_detect_n: bit/qualifier/mode inputs and the match pulses and hit counters.
// The stream source and status block act as master; the detector is the slave.
interface seq_detect_n_if #(
  parameter int unsigned CNT_W = 8
);

  logic             X;
  logic             en;
  logic             overlap;
  logic             clr_cnt;
  logic             Z1;
  logic             Z2;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  modport master (
    output X, en, overlap, clr_cnt,
    input  Z1, Z2, cnt1, cnt2
  );

  modport slave (
    input  X, en, overlap, clr_cnt,
    output Z1, Z2, cnt1, cnt2
  );

endinterface

// File: rtl/seq_detect_n.sv
// Two-pattern serial sequence detector with sample enable, overlap mode select
// and saturating per-pattern hit counters. All outputs are registered.
module seq_detect_n #(
  parameter int unsigned     LEN   = 3,
  parameter logic [LEN-1:0]  PAT1  = LEN'(3'b110),
  parameter logic [LEN-1:0]  PAT2  = LEN'(3'b100),
  parameter int unsigned     CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_detect_n_if.slave   bus
);

  localparam int unsigned NPAT   = 2;
  localparam int unsigned FILL_W = $clog2(LEN + 1);

  // Elaboration-time parameter legality
  if (LEN < 2 || LEN > 16) begin : g_bad_len
    $fatal(1, "seq_detect_n: LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "seq_detect_n: CNT_W must be in 1..32");
  end

  function automatic logic [LEN-1:0] pat_of(input int unsigned k);
    return (k == 0) ? PAT1 : PAT2;
  endfunction

  // Only LEN-1 past bits are needed: the newest bit completes the window.
  logic [LEN-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q [NPAT];
  logic [FILL_W-1:0] fill_d [NPAT];
  logic [CNT_W-1:0]  cnt_q  [NPAT];
  logic [CNT_W-1:0]  cnt_d  [NPAT];
  logic [NPAT-1:0]   z_q, z_d;
  logic [LEN-1:0]    cand_c;
  logic [NPAT-1:0]   match_c;

  always_comb begin
    cand_c  = {hist_q, bus.X};
    hist_d  = hist_q;
    z_d     = '0;
    match_c = '0;
    for (int unsigned k = 0; k < NPAT; k++) begin
      fill_d[k] = fill_q[k];
      cnt_d[k]  = cnt_q[k];
    end

    if (bus.en) begin
      hist_d = cand_c[LEN-2:0];
    end

    for (int unsigned k = 0; k < NPAT; k++) begin
      match_c[k] = bus.en && (fill_q[k] >= FILL_W'(LEN - 1)) && (cand_c == pat_of(k));
      z_d[k]     = match_c[k];

      // A non-overlapped hit restarts this pattern's fill so its bits are not reused.
      if (bus.en) begin
        if (match_c[k] && !bus.overlap) begin
          fill_d[k] = '0;
        end else if (fill_q[k] != FILL_W'(LEN)) begin
          fill_d[k] = fill_q[k] + FILL_W'(1);
        end
      end

      // Clear wins over a coincident hit; counter saturates at all-ones.
      if (bus.clr_cnt) begin
        cnt_d[k] = '0;
      end else if (match_c[k] && !(&cnt_q[k])) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      z_q    <= '0;
      for (int unsigned k = 0; k < NPAT; k++) begin
        fill_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      hist_q <= hist_d;
      z_q    <= z_d;
      for (int unsigned k = 0; k < NPAT; k++) begin
        fill_q[k] <= fill_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign bus.Z1   = z_q[0];
  assign bus.Z2   = z_q[1];
  assign bus.cnt1 = cnt_q[0];
  assign bus.cnt2 = cnt_q[1];

endmodule

// File: tb/tb_seq_detect_n.sv
// Self-checking bench: five detector configurations share one stimulus stream and
// are compared every cycle against a bit-queue reference model.
module tb_seq_detect_n;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst, x, en, ov, clr;

  always #5 clk = ~clk;

  seq_detect_n_if #(.CNT_W(8)) if0 ();
  seq_detect_n_if #(.CNT_W(8)) if1 ();
  seq_detect_n_if #(.CNT_W(2)) if2 ();
  seq_detect_n_if #(.CNT_W(8)) if3 ();
  seq_detect_n_if #(.CNT_W(4)) if4 ();

  assign if0.X = x; assign if0.en = en; assign if0.overlap = ov; assign if0.clr_cnt = clr;
  assign if1.X = x; assign if1.en = en; assign if1.overlap = ov; assign if1.clr_cnt = clr;
  assign if2.X = x; assign if2.en = en; assign if2.overlap = ov; assign if2.clr_cnt = clr;
  assign if3.X = x; assign if3.en = en; assign if3.overlap = ov; assign if3.clr_cnt = clr;
  assign if4.X = x; assign if4.en = en; assign if4.overlap = ov; assign if4.clr_cnt = clr;

  seq_detect_n u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_detect_n #(.PAT1(3'b101)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_detect_n #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  seq_detect_n #(.PAT1(3'b110), .PAT2(3'b110)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  seq_detect_n #(.LEN(5), .PAT1(5'b10110), .PAT2(5'b11111), .CNT_W(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // Reference model configuration per instance
  int m_len [NI] = '{3, 3, 3, 3, 5};
  int m_p1  [NI] = '{6, 5, 6, 6, 22};
  int m_p2  [NI] = '{4, 4, 4, 6, 31};
  int m_max [NI] = '{255, 255, 3, 255, 15};

  // Bits consumed since reset; per-pattern count of bits since reset or last non-overlapped hit
  bit hq [$];
  int since1 [NI];
  int since2 [NI];
  int e_cnt1 [NI];
  int e_cnt2 [NI];
  bit e_z1   [NI];
  bit e_z2   [NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int tail(input int len);
    int v = 0;
    for (int j = 0; j < len; j++) v = (v << 1) | int'(hq[hq.size() - len + j]);
    return v;
  endfunction

  function automatic bit hit(input int len, input int pat, input int since);
    if (since < len) return 1'b0;
    return tail(len) == pat;
  endfunction

  task automatic model_edge();
    if (rst) begin
      hq.delete();
      for (int i = 0; i < NI; i++) begin
        since1[i] = 0; since2[i] = 0; e_cnt1[i] = 0; e_cnt2[i] = 0;
        e_z1[i] = 1'b0; e_z2[i] = 1'b0;
      end
      return;
    end
    if (en) begin
      hq.push_back(x);
      if (hq.size() > 32) void'(hq.pop_front());
    end
    for (int i = 0; i < NI; i++) begin
      bit m1 = 1'b0;
      bit m2 = 1'b0;
      if (en) begin
        int s1 = since1[i] + 1;
        int s2 = since2[i] + 1;
        m1 = hit(m_len[i], m_p1[i], s1);
        m2 = hit(m_len[i], m_p2[i], s2);
        since1[i] = (m1 && !ov) ? 0 : ((s1 > 1000) ? 1000 : s1);
        since2[i] = (m2 && !ov) ? 0 : ((s2 > 1000) ? 1000 : s2);
      end
      e_z1[i] = m1;
      e_z2[i] = m2;
      if (clr) begin
        e_cnt1[i] = 0; e_cnt2[i] = 0;
      end else begin
        if (m1 && e_cnt1[i] < m_max[i]) e_cnt1[i]++;
        if (m2 && e_cnt2[i] < m_max[i]) e_cnt2[i]++;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic z1, input logic z2,
                            input logic [31:0] c1, input logic [31:0] c2);
    check($sformatf("u%0d_z1", i), 32'(z1), 32'(e_z1[i]));
    check($sformatf("u%0d_z2", i), 32'(z2), 32'(e_z2[i]));
    check($sformatf("u%0d_cnt1", i), c1, 32'(e_cnt1[i]));
    check($sformatf("u%0d_cnt2", i), c2, 32'(e_cnt2[i]));
  endtask

  task automatic check_all();
    check_inst(0, if0.Z1, if0.Z2, 32'(if0.cnt1), 32'(if0.cnt2));
    check_inst(1, if1.Z1, if1.Z2, 32'(if1.cnt1), 32'(if1.cnt2));
    check_inst(2, if2.Z1, if2.Z2, 32'(if2.cnt1), 32'(if2.cnt2));
    check_inst(3, if3.Z1, if3.Z2, 32'(if3.cnt1), 32'(if3.cnt2));
    check_inst(4, if4.Z1, if4.Z2, 32'(if4.cnt1), 32'(if4.cnt2));
  endtask

  task automatic step(input logic r, input logic xi, input logic ei, input logic oi, input logic ci);
    rst = r; x = xi; en = ei; ov = oi; clr = ci;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Send n bits MSB first, with 'gap' idle (en=0) cycles after each bit
  task automatic send(input logic [15:0] bits, input int n, input logic oi, input int gap);
    logic [15:0] b = bits;
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b0, b[k], 1'b1, oi, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, oi, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; en = 1'b0; ov = 1'b1; clr = 1'b0;
    do_reset();
    do_reset();
    check("rst_z1", 32'(if0.Z1), 32'd0);
    check("rst_cnt1", 32'(if0.cnt1), 32'd0);

    // 1,1,0,0 on defaults: Z1 after bit 3, Z2 after bit 4
    send(16'b1100, 4, 1'b1, 0);
    check("tp1_cnt1", 32'(if0.cnt1), 32'd1);
    check("tp1_cnt2", 32'(if0.cnt2), 32'd1);

    // PAT1=101 overlapping then non-overlapping
    do_reset();
    send(16'b10101, 5, 1'b1, 0);
    check("tp2_ov_cnt1", 32'(if1.cnt1), 32'd2);
    do_reset();
    send(16'b10101, 5, 1'b0, 0);
    check("tp2_nov_cnt1", 32'(if1.cnt1), 32'd1);
    send(16'b01, 2, 1'b0, 0);
    check("tp2_nov_z1", 32'(if1.Z1), 32'd1);
    check("tp2_nov_cnt1b", 32'(if1.cnt1), 32'd2);

    // en gaps do not break the sequence
    do_reset();
    send(16'b110, 3, 1'b1, 2);
    check("tp3_cnt1", 32'(if0.cnt1), 32'd1);

    // 2-bit counter saturation then clear on a coincident match
    do_reset();
    send(16'b110110110110110, 15, 1'b1, 0);
    check("tp4_sat", 32'(if2.cnt1), 32'd3);
    send(16'b11, 2, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("tp4_clr_cnt1", 32'(if2.cnt1), 32'd0);
    check("tp4_clr_z1", 32'(if2.Z1), 32'd1);

    // Reset mid-stream discards history
    do_reset();
    send(16'b11, 2, 1'b1, 0);
    do_reset();
    check("tp5_z1", 32'(if0.Z1), 32'd0);
    send(16'b0, 1, 1'b1, 0);
    check("tp5_nohit", 32'(if0.Z1), 32'd0);
    send(16'b110, 3, 1'b1, 0);
    check("tp5_hit", 32'(if0.cnt1), 32'd1);

    // Identical patterns pulse together
    do_reset();
    send(16'b110, 3, 1'b1, 0);
    check("tp6_z1", 32'(if3.Z1), 32'd1);
    check("tp6_z2", 32'(if3.Z2), 32'd1);
    check("tp6_cnt1", 32'(if3.cnt1), 32'd1);
    check("tp6_cnt2", 32'(if3.cnt2), 32'd1);

    // Randomized stream with sparse resets, clears and mode changes
    begin
      logic cur_ov = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 19) == 0) cur_ov = ~cur_ov;
        step(1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0),
             cur_ov,
             1'($urandom_range(0, 49) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
